// File: rtl/audio_if_pkg.sv
// Shared constants and FSM encoding for the serial-audio capture blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package audio_if_pkg;

  localparam int MODE_I2S = 0;  // MSB one bclk after the lrclk transition
  localparam int MODE_LJ  = 1;  // MSB on the lrclk transition

  typedef enum logic [1:0] {
    WAIT_L    = 2'd0,
    SHIFT     = 2'd1,
    IDLE_SLOT = 2'd2
  } state_t;

endpackage

// File: rtl/lrclk_edge_det.sv
// Word-select edge detector: registers lrclk and reports slot starts and channel.
// Latency: I2S flags the edge one bclk after lrclk moves; LJ flags it combinationally on the move.
// Backpressure: none; free-running on every bclk falling edge.
module lrclk_edge_det
  import audio_if_pkg::*;
#(
  parameter int   MODE   = MODE_I2S,
  parameter logic LR_POL = 1'b0
) (
  input  logic bclk,
  input  logic reset_n,
  input  logic lrclk,
  output logic lr_edge,
  output logic chan
);

  logic lr_d1;
  logic lr_d2;

  // Two-deep lrclk history; reset to the left level so the first edge seen is a real one
  always_ff @(negedge bclk or negedge reset_n) begin
    if (!reset_n) begin
      lr_d1 <= LR_POL;
      lr_d2 <= LR_POL;
    end else begin
      lr_d1 <= lrclk;
      lr_d2 <= lr_d1;
    end
  end

  // I2S looks one bit later than LJ so the edge lines up with the delayed MSB
  always_comb begin
    lr_edge = 1'b0;
    chan    = LR_POL;
    if (MODE == MODE_LJ) begin
      lr_edge = lrclk ^ lr_d1;
      chan    = lrclk;
    end else begin
      lr_edge = lr_d1 ^ lr_d2;
      chan    = lr_d1;
    end
  end

endmodule

// File: rtl/i2s_stereo_rx.sv
// Stereo I2S / left-justified capture presenting a coherent sign-extended L/R pair.
// Latency: sample_valid rises on the falling edge that shifts in the right-word LSB.
// Backpressure: none; sinks must take each one-cycle sample_valid pulse as it comes.
module i2s_stereo_rx
  import audio_if_pkg::*;
#(
  parameter int   DATA_W = 16,
  parameter int   OUT_W  = 16,
  parameter int   MODE   = MODE_I2S,
  parameter logic LR_POL = 1'b0
) (
  input  logic             bclk,
  input  logic             reset_n,
  input  logic             lrclk,
  input  logic             in_data,
  output logic [OUT_W-1:0] left_data,
  output logic [OUT_W-1:0] right_data,
  output logic             sample_valid,
  output logic             frame_err,
  output logic             err_sticky
);

  localparam int CNT_W = $clog2(DATA_W);

  state_t              state;
  logic [CNT_W-1:0]    bit_cnt;     // bits still to come after the current one
  logic [DATA_W-2:0]   shreg;       // bits received so far; the LSB joins straight from in_data
  logic                cur_left;    // word being shifted belongs to the left channel
  logic [OUT_W-1:0]    left_hold;   // left word waiting for its right partner
  logic                left_ok;
  logic                lr_edge;
  logic                chan;
  logic                is_left;
  logic [DATA_W-1:0]   word;

  lrclk_edge_det #(
    .MODE   (MODE),
    .LR_POL (LR_POL)
  ) u_edge (
    .bclk    (bclk),
    .reset_n (reset_n),
    .lrclk   (lrclk),
    .lr_edge (lr_edge),
    .chan    (chan)
  );

  assign is_left = (chan == LR_POL);
  assign word    = {shreg, in_data};

  function automatic logic [OUT_W-1:0] sext(input logic [DATA_W-1:0] w);
    return OUT_W'($signed(w));
  endfunction

  // Slot FSM, shifter and output registers; the bit on an edge cycle is the new word's MSB
  always_ff @(negedge bclk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= WAIT_L;
      bit_cnt      <= '0;
      shreg        <= '0;
      cur_left     <= 1'b0;
      left_hold    <= '0;
      left_ok      <= 1'b0;
      left_data    <= '0;
      right_data   <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
      err_sticky   <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
      case (state)
        WAIT_L: begin
          // Nothing counts until the stream is aligned on a left slot
          if (lr_edge && is_left) begin
            state    <= SHIFT;
            cur_left <= 1'b1;
            shreg    <= (DATA_W-1)'(in_data);
            bit_cnt  <= CNT_W'(DATA_W-2);
          end
        end
        SHIFT: begin
          if (lr_edge) begin
            // Slot ended before the word did: drop it and break any pending pair
            frame_err  <= 1'b1;
            err_sticky <= 1'b1;
            left_ok    <= 1'b0;
            cur_left   <= is_left;
            shreg      <= (DATA_W-1)'(in_data);
            bit_cnt    <= CNT_W'(DATA_W-2);
          end else begin
            shreg <= {shreg[DATA_W-3:0], in_data};
            if (bit_cnt == '0) begin
              state <= IDLE_SLOT;
              if (cur_left) begin
                left_hold <= sext(word);
                left_ok   <= 1'b1;
              end else if (left_ok) begin
                left_data    <= left_hold;
                right_data   <= sext(word);
                sample_valid <= 1'b1;
                left_ok      <= 1'b0;
              end else begin
                // Right word with no left partner
                frame_err  <= 1'b1;
                err_sticky <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
            end
          end
        end
        IDLE_SLOT: begin
          // Slot padding beyond DATA_W is ignored until the next edge
          if (lr_edge) begin
            state    <= SHIFT;
            cur_left <= is_left;
            shreg    <= (DATA_W-1)'(in_data);
            bit_cnt  <= CNT_W'(DATA_W-2);
          end
        end
        default: state <= WAIT_L;
      endcase
    end
  end

endmodule
